adc_ctrl_axil_slave: RTL and testbench



---
 rtl/adc_ctrl_pkg.sv | 33 +++
 rtl/adc_ctrl_axil_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_ctrl_axil_slave.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ctrl_pkg.sv
// rtl/adc_ctrl_pkg.sv - register map, field positions and FSM types for the AD9643 control slave
package adc_ctrl_pkg;

    localparam logic [2:0] REG_CTRL       = 3'd0;
    localparam logic [2:0] REG_STATUS     = 3'd1;
    localparam logic [2:0] REG_SAMPLE_CNT = 3'd2;
    localparam logic [2:0] REG_PATTERN    = 3'd3;
    localparam logic [2:0] REG_ID         = 3'd4;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_PATTERN_EN_BIT = 1;
    localparam int CTRL_PAT_SEL_LSB    = 2;
    localparam int CTRL_SOFT_RST_BIT   = 8;
    localparam int PATTERN_W           = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        PAT_FIXED    = 2'd0,
        PAT_RAMP     = 2'd1,
        PAT_TOGGLE   = 2'd2,
        PAT_RESERVED = 2'd3
    } pattern_sel_e;

    typedef enum logic [2:0] {
        SEL_CTRL, SEL_STATUS, SEL_CNT, SEL_PATTERN, SEL_ID, SEL_NONE
    } reg_sel_e;

    typedef enum logic { W_IDLE, W_RESP } wr_state_e;
    typedef enum logic { R_IDLE, R_DATA } rd_state_e;

endpackage

// File: rtl/adc_ctrl_axil_slave.sv
// rtl/adc_ctrl_axil_slave.sv - AXI4-Lite control/status register slave for the AD9643 capture path
module adc_ctrl_axil_slave
    import adc_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'hAD96_4301
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  stat_overflow,
    input  logic                  stat_sample_inc,
    output logic                  ctrl_enable,
    output logic                  ctrl_pattern_en,
    output logic [1:0]            ctrl_pattern_sel,
    output logic [13:0]           ctrl_pattern_val,
    output logic                  ctrl_soft_rst
);

    localparam int WW = ADDR_WIDTH - 2;

    function automatic reg_sel_e decode(input logic [WW-1:0] w);
        if (w == WW'(REG_CTRL))       return SEL_CTRL;
        if (w == WW'(REG_STATUS))     return SEL_STATUS;
        if (w == WW'(REG_SAMPLE_CNT)) return SEL_CNT;
        if (w == WW'(REG_PATTERN))    return SEL_PATTERN;
        if (w == WW'(REG_ID))         return SEL_ID;
        return SEL_NONE;
    endfunction

    wr_state_e              wr_state_q;
    logic                   awready_q, wready_q, aw_done_q, w_done_q;
    logic [WW-1:0]          aw_word_q;
    logic [PATTERN_W-1:0]   wdata_q;
    logic [1:0]             wstrb_q;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;

    rd_state_e              rd_state_q;
    logic                   arready_q, rvalid_q;
    logic [1:0]             rresp_q;
    logic [31:0]            rdata_q;

    logic                   enable_q, enable_d, pat_en_q, pat_en_d;
    pattern_sel_e           pat_sel_q, pat_sel_d;
    logic                   soft_rst_q, soft_rst_d;
    logic [PATTERN_W-1:0]   pattern_q, pattern_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            sample_cnt_q, sample_cnt_d;

    logic                   aw_hs, w_hs, aw_have, w_have, wr_commit;
    logic [WW-1:0]          wr_word;
    logic [PATTERN_W-1:0]   wr_data;
    logic [1:0]             wr_strb;
    reg_sel_e               wr_sel, rd_sel;
    logic [31:0]            rd_data;

    // The channel that arrives second is taken straight from the bus so the
    // register update lands on the same edge as its handshake.
    assign aw_hs     = s_axi_awvalid & awready_q;
    assign w_hs      = s_axi_wvalid & wready_q;
    assign aw_have   = aw_done_q | aw_hs;
    assign w_have    = w_done_q | w_hs;
    assign wr_commit = (wr_state_q == W_IDLE) & aw_have & w_have;
    assign wr_word   = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_word_q;
    assign wr_data   = w_hs ? s_axi_wdata[PATTERN_W-1:0] : wdata_q;
    assign wr_strb   = w_hs ? s_axi_wstrb[1:0] : wstrb_q;
    assign wr_sel    = decode(wr_word);
    assign rd_sel    = decode(s_axi_araddr[ADDR_WIDTH-1:2]);

    always_comb begin
        enable_d     = enable_q;
        pat_en_d     = pat_en_q;
        pat_sel_d    = pat_sel_q;
        soft_rst_d   = 1'b0;
        pattern_d    = pattern_q;
        overflow_d   = overflow_q;
        sample_cnt_d = sample_cnt_q;
        if (wr_commit && wr_sel == SEL_CTRL) begin
            if (wr_strb[0]) begin
                enable_d  = wr_data[CTRL_ENABLE_BIT];
                pat_en_d  = wr_data[CTRL_PATTERN_EN_BIT];
                pat_sel_d = pattern_sel_e'(wr_data[CTRL_PAT_SEL_LSB +: 2]);
            end
            if (wr_strb[1]) soft_rst_d = wr_data[CTRL_SOFT_RST_BIT];
        end
        if (wr_commit && wr_sel == SEL_PATTERN) begin
            if (wr_strb[0]) pattern_d[7:0]  = wr_data[7:0];
            if (wr_strb[1]) pattern_d[13:8] = wr_data[13:8];
        end
        if (wr_commit && wr_sel == SEL_STATUS && wr_strb[0] && wr_data[0]) overflow_d = 1'b0;
        if (stat_overflow) overflow_d = 1'b1;
        // The counter is held clear for the whole soft-reset pulse, so a
        // sample arriving alongside it is discarded.
        if (soft_rst_q)           sample_cnt_d = '0;
        else if (stat_sample_inc) sample_cnt_d = sample_cnt_q + 32'd1;
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_CTRL:    rd_data = {28'd0, pat_sel_q, pat_en_q, enable_q};
            SEL_STATUS:  rd_data = {31'd0, overflow_q};
            SEL_CNT:     rd_data = sample_cnt_q;
            SEL_PATTERN: rd_data = {18'd0, pattern_q};
            SEL_ID:      rd_data = ID_VALUE;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            enable_q     <= 1'b0;
            pat_en_q     <= 1'b0;
            pat_sel_q    <= PAT_FIXED;
            soft_rst_q   <= 1'b0;
            pattern_q    <= '0;
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            enable_q     <= enable_d;
            pat_en_q     <= pat_en_d;
            pat_sel_q    <= pat_sel_d;
            soft_rst_q   <= soft_rst_d;
            pattern_q    <= pattern_d;
            overflow_q   <= overflow_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_word_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) aw_word_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
                    if (w_hs) begin
                        wdata_q <= s_axi_wdata[PATTERN_W-1:0];
                        wstrb_q <= s_axi_wstrb[1:0];
                    end
                    if (wr_commit) begin
                        wr_state_q <= W_RESP;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                    end else begin
                        aw_done_q  <= aw_have;
                        w_done_q   <= w_have;
                        awready_q  <= ~aw_have;
                        wready_q   <= ~w_have;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        wr_state_q <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi_arvalid && arready_q) begin
                        rd_state_q <= R_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_data;
                        rresp_q    <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rd_state_q <= R_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready    = awready_q;
    assign s_axi_wready     = wready_q;
    assign s_axi_bvalid     = bvalid_q;
    assign s_axi_bresp      = bresp_q;
    assign s_axi_arready    = arready_q;
    assign s_axi_rvalid     = rvalid_q;
    assign s_axi_rresp      = rresp_q;
    assign s_axi_rdata      = rdata_q;
    assign ctrl_enable      = enable_q;
    assign ctrl_pattern_en  = pat_en_q;
    assign ctrl_pattern_sel = pat_sel_q;
    assign ctrl_pattern_val = pattern_q;
    assign ctrl_soft_rst    = soft_rst_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata[DATA_WIDTH-1:PATTERN_W], s_axi_wstrb[3:2]};

endmodule

// File: tb/tb_adc_ctrl_axil_slave.sv
// tb/tb_adc_ctrl_axil_slave.sv - randomized self-checking bench for adc_ctrl_axil_slave
module tb_adc_ctrl_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        stat_overflow, stat_sample_inc;
    logic        ctrl_enable, ctrl_pattern_en, ctrl_soft_rst;
    logic [1:0]  ctrl_pattern_sel;
    logic [13:0] ctrl_pattern_val;

    always #5 clk = ~clk;

    adc_ctrl_axil_slave dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .stat_overflow(stat_overflow), .stat_sample_inc(stat_sample_inc),
        .ctrl_enable(ctrl_enable), .ctrl_pattern_en(ctrl_pattern_en), .ctrl_pattern_sel(ctrl_pattern_sel),
        .ctrl_pattern_val(ctrl_pattern_val), .ctrl_soft_rst(ctrl_soft_rst)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: the register file as plain values.
    logic [3:0]  m_ctrl;
    logic [13:0] m_pat;
    logic        m_ovf;
    logic [31:0] m_cnt;
    logic        m_soft;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a / 4)
            0: return {28'd0, m_ctrl};
            1: return {31'd0, m_ovf};
            2: return m_cnt;
            3: return {18'd0, m_pat};
            4: return 32'hAD96_4301;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input logic [4:0] a);
        return (a / 4 <= 4) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        m_soft = 1'b0;
        case (a / 4)
            0: begin
                v = merge({28'd0, m_ctrl}, d, s);
                m_ctrl = v[3:0];
                m_soft = v[8];
                if (m_soft) m_cnt = 0;
            end
            1: if (s[0] && d[0]) m_ovf = 1'b0;
            3: begin
                v = merge({18'd0, m_pat}, d, s);
                m_pat = v[13:0];
            end
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_ctrl = 0; m_pat = 0; m_ovf = 0; m_cnt = 0; m_soft = 0;
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, ".enable"}, ctrl_enable, m_ctrl[0]);
        chk({tag, ".pat_en"}, ctrl_pattern_en, m_ctrl[1]);
        chk({tag, ".pat_sel"}, ctrl_pattern_sel, m_ctrl[3:2]);
        chk({tag, ".pat_val"}, ctrl_pattern_val, m_pat);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] er;
        int t;
        er = m_resp(a);
        fork
            begin
                int ta;
                repeat (aw_dly) begin @(posedge clk); #1; end
                awaddr = a; awvalid = 1'b1; ta = 0;
                while (!awready && ta < 50) begin @(posedge clk); #1; ta++; end
                chk("aw_handshake", awready, 1'b1);
                @(posedge clk); #1; awvalid = 1'b0;
            end
            begin
                int tw;
                repeat (w_dly) begin @(posedge clk); #1; end
                wdata = d; wstrb = s; wvalid = 1'b1; tw = 0;
                while (!wready && tw < 50) begin @(posedge clk); #1; tw++; end
                chk("w_handshake", wready, 1'b1);
                @(posedge clk); #1; wvalid = 1'b0;
            end
        join
        m_write(a, d, s);
        chk("bvalid_on_commit", bvalid, 1'b1);
        chk("soft_rst_pulse", ctrl_soft_rst, m_soft);
        check_ctrl("wr");
        t = 0;
        repeat (b_dly) begin
            chk("bvalid_held", bvalid, 1'b1);
            chk("aw_blocked", awready, 1'b0);
            chk("w_blocked", wready, 1'b0);
            @(posedge clk); #1; t++;
            chk("soft_rst_once", ctrl_soft_rst, 1'b0);
        end
        chk("bresp", bresp, er);
        bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        chk("bvalid_clear", bvalid, 1'b0);
        chk("soft_rst_end", ctrl_soft_rst, 1'b0);
        m_soft = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, input int r_dly, input logic [31:0] ed, input logic [1:0] er);
        int t;
        araddr = a; arvalid = 1'b1; t = 0;
        while (!arready && t < 50) begin @(posedge clk); #1; t++; end
        chk("ar_handshake", arready, 1'b1);
        @(posedge clk); #1; arvalid = 1'b0;
        chk("rvalid_latency", rvalid, 1'b1);
        repeat (r_dly) begin
            chk("rdata_stable", rdata, ed);
            chk("rvalid_held", rvalid, 1'b1);
            @(posedge clk); #1;
        end
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        rready = 1'b1;
        @(posedge clk); #1; rready = 1'b0;
        chk("rvalid_clear", rvalid, 1'b0);
    endtask

    task automatic rd_chk(input logic [4:0] a);
        axi_read(a, $urandom_range(0, 2), m_rdata(a), m_resp(a));
    endtask

    task automatic inc_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            stat_sample_inc = 1'b1;
            @(posedge clk); #1; stat_sample_inc = 1'b0;
            m_cnt = m_cnt + 1;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic ovf_pulse();
        stat_overflow = 1'b1;
        @(posedge clk); #1; stat_overflow = 1'b0;
        m_ovf = 1'b1;
    endtask

    initial begin
        logic [31:0] old_ctrl;
        rst_n = 1'b0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0; stat_overflow = 0; stat_sample_inc = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.awready", awready, 1'b0);
        chk("rst.wready", wready, 1'b0);
        chk("rst.arready", arready, 1'b0);
        chk("rst.bvalid", bvalid, 1'b0);
        chk("rst.rvalid", rvalid, 1'b0);
        chk("rst.soft_rst", ctrl_soft_rst, 1'b0);
        check_ctrl("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst.awready", awready, 1'b1);
        chk("post_rst.wready", wready, 1'b1);
        chk("post_rst.arready", arready, 1'b1);
        chk("post_rst.rdata", rdata, 32'd0);
        chk("post_rst.bresp", bresp, 2'b00);

        axi_write(5'h00, 32'h0000_0007, 4'hF, 0, 0, 0);
        chk("ctrl7.pattern_sel", ctrl_pattern_sel, 2'd1);
        rd_chk(5'h00);

        axi_write(5'h0C, 32'h0000_0155, 4'hF, 3, 0, 5);
        axi_write(5'h0C, 32'h0000_0000, 4'hF, 0, 2, 0);
        rd_chk(5'h10);
        axi_read(5'h14, 1, 32'd0, 2'b10);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
        check_ctrl("unmapped_wr");

        ovf_pulse();
        rd_chk(5'h04);
        awaddr = 5'h04; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'h1; wvalid = 1'b1; stat_overflow = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; stat_overflow = 1'b0;
        chk("w1c_race.bvalid", bvalid, 1'b1);
        bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
        axi_read(5'h04, 0, 32'd1, 2'b00);
        axi_write(5'h04, 32'h1, 4'h1, 1, 0, 0);
        axi_read(5'h04, 0, 32'd0, 2'b00);

        inc_pulses(10);
        axi_read(5'h08, 0, 32'd10, 2'b00);
        axi_write(5'h00, {23'd0, 1'b1, 4'd0, m_ctrl}, 4'h3, 0, 0, 0);
        axi_read(5'h08, 0, 32'd0, 2'b00);
        dut.sample_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        inc_pulses(1);
        axi_read(5'h08, 0, 32'd0, 2'b00);

        axi_write(5'h0C, 32'h0000_3ABC, 4'b0001, 0, 0, 0);
        axi_read(5'h0C, 0, 32'h0000_00BC, 2'b00);

        old_ctrl = m_rdata(5'h00);
        fork
            axi_write(5'h00, 32'h0000_000A, 4'hF, 0, 0, 0);
            axi_read(5'h00, 0, old_ctrl, 2'b00);
        join
        rd_chk(5'h00);

        for (int i = 0; i < 200; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1: axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                2:    rd_chk(a);
                3:    inc_pulses($urandom_range(1, 5));
                default: ovf_pulse();
            endcase
        end
        for (int w = 0; w < 8; w++) rd_chk(5'(w * 4));

        awaddr = 5'h00; awvalid = 1'b1; wdata = 32'h0000_000F; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        m_write(5'h00, 32'h0000_000F, 4'hF);
        chk("pre_abort.bvalid", bvalid, 1'b1);
        chk("pre_abort.enable", ctrl_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.bvalid", bvalid, 1'b0);
        chk("abort.awready", awready, 1'b0);
        m_reset();
        check_ctrl("abort");
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort.bvalid_after", bvalid, 1'b0);
        rd_chk(5'h00);
        rd_chk(5'h08);
        rd_chk(5'h0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
